// File: rtl/pll_lock_ctrl.sv
`default_nettype none
// =============================================================================
// pll_lock_ctrl : PLL bring-up supervisor (reset pulse, lock qualify, retry/fail)
// Revision 1.0
// =============================================================================
module pll_lock_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int MAX_RETRY    = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       lol,
   output logic       fail,
   output logic [3:0] retry_cnt
);

   localparam int c_max_a   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
   localparam int c_max_p   = (c_max_a > LOCK_TIMEOUT) ? c_max_a : LOCK_TIMEOUT;
   localparam int c_timer_w = $clog2(c_max_p) + 1;

   localparam logic [c_timer_w-1:0] c_timer_one    = c_timer_w'(1);
   localparam logic [c_timer_w-1:0] c_rst_last     = c_timer_w'(RST_CYCLES - 1);
   localparam logic [c_timer_w-1:0] c_stable_last  = c_timer_w'(LOCK_STABLE - 1);
   localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(LOCK_TIMEOUT - 1);
   localparam logic [3:0]           c_retry_max    = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [c_timer_w-1:0]   timer_q, timer_d;
   logic [3:0]             retry_q, retry_d;
   logic                   meta_q, meta_d;
   logic                   locked_s_q, locked_s_d;
   logic                   pll_rst_q, pll_rst_d;
   logic                   sys_rst_n_q, sys_rst_n_d;
   logic                   ready_q, ready_d;
   logic                   lol_q, lol_d;
   logic                   fail_q, fail_d;

   always_comb begin
      meta_d     = pll_locked;
      locked_s_d = meta_q;
      state_d    = state_q;
      timer_d    = timer_q;
      retry_d    = retry_q;
      lol_d      = 1'b0;

      case (state_q)
         RESET_PLL: begin
            timer_d = timer_q + c_timer_one;
            if (timer_q == c_rst_last) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            timer_d = timer_q + c_timer_one;
            if (locked_s_q) begin
               state_d = STABLE;
            end else if (timer_q == c_timeout_last) begin
               if (retry_q == c_retry_max) begin
                  state_d = FAIL;
               end else begin
                  state_d = RESET_PLL;
                  retry_d = retry_q + 4'd1;
               end
            end
         end
         STABLE: begin
            timer_d = timer_q + c_timer_one;
            if (!locked_s_q) begin
               state_d = WAIT_LOCK;
            end else if (timer_q == c_stable_last) begin
               state_d = RUN;
               retry_d = 4'd0;
            end
         end
         RUN: begin
            // Loss of lock takes priority over a simultaneous relock request
            if (!locked_s_q) begin
               state_d = RESET_PLL;
               lol_d   = 1'b1;
            end else if (relock_req) begin
               state_d = RESET_PLL;
            end
         end
         FAIL: begin
            if (relock_req) begin
               state_d = RESET_PLL;
               retry_d = 4'd0;
            end
         end
         default: begin
            state_d = RESET_PLL;
         end
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end

      // Level outputs follow the state register, so they settle one cycle after
      // each transition; pll_rst and sys_rst_n come from disjoint state sets.
      pll_rst_d   = (state_q == RESET_PLL) || (state_q == FAIL);
      sys_rst_n_d = (state_q == RUN);
      ready_d     = (state_q == RUN);
      fail_d      = (state_q == FAIL);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_PLL;
         timer_q     <= '0;
         retry_q     <= 4'd0;
         meta_q      <= 1'b0;
         locked_s_q  <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         lol_q       <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         meta_q      <= meta_d;
         locked_s_q  <= locked_s_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         lol_q       <= lol_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = ready_q;
   assign lol       = lol_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
`default_nettype none
// =============================================================================
// tb_pll_lock_ctrl : directed vector table plus multi-cycle corner sequences
// Revision 1.0
// =============================================================================
module tb_pll_lock_ctrl;

   localparam int RST_CYCLES   = 4;
   localparam int LOCK_STABLE  = 8;
   localparam int LOCK_TIMEOUT = 32;
   localparam int MAX_RETRY    = 2;

   logic       refclk     = 1'b0;
   logic       rst_n      = 1'b0;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       lol;
   logic       fail;
   logic [3:0] retry_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic excl_viol = 1'b0;

   always #5 refclk = ~refclk;

   pll_lock_ctrl #(
      .RST_CYCLES  (RST_CYCLES),
      .LOCK_STABLE (LOCK_STABLE),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .MAX_RETRY   (MAX_RETRY)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .relock_req(relock_req),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .lol       (lol),
      .fail      (fail),
      .retry_cnt (retry_cnt)
   );

   // expected packing: {pll_rst, sys_rst_n, ready, lol, fail, retry_cnt}
   typedef struct {
      string      name;
      int         n;
      logic       rst_n;
      logic       locked;
      logic       relock;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input int n, input logic r, input logic l,
                               input logic q, input logic pr, input logic sr, input logic rd,
                               input logic ll, input logic fl, input logic [3:0] rc);
      vec_t v;
      v.name   = name;
      v.n      = n;
      v.rst_n  = r;
      v.locked = l;
      v.relock = q;
      v.exp    = {pr, sr, rd, ll, fl, rc};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] outs();
      return {pll_rst, sys_rst_n, ready, lol, fail, retry_cnt};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      @(negedge refclk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge refclk);
      rst_n = 1'b1;
   endtask

   // returns number of edges until ready is seen, or -1 on expiry
   task automatic wait_ready(input int max, output int cycles);
      cycles = -1;
      for (int k = 1; k <= max; k++) begin
         step(1);
         if (ready) begin
            cycles = k;
            break;
         end
      end
   endtask

   always @(negedge refclk) begin
      if (sys_rst_n && pll_rst) excl_viol <= 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int w;
      int guard;
      int lol_cnt;
      int rise_cnt;
      logic prev;

      // Normal bring-up with relock request in RUN
      vecs.push_back(mk("reset",       3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("rel_e1",      1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("rstpll_e4",   3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("wait_e5",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("stable_e16", 11, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("run_e17",     1, 1, 1, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk("run_hold",   10, 1, 1, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk("relock_in",   1, 1, 1, 1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk("relock_rst",  1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("relock_e32",  3, 1, 1, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("relock_e33",  1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("relock_e41",  8, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("relock_e42",  1, 1, 1, 0, 0, 1, 1, 0, 0, 0));
      // No lock: two retries then FAIL, relock_req ignored in WAIT_LOCK
      vecs.push_back(mk("b_reset",     2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("b_to1_e36",  36, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk("b_p1_e37",    1, 1, 0, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk("b_p1_e40",    3, 1, 0, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk("b_w_e41",     1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk("b_rq_ign1",   1, 1, 0, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk("b_rq_ign2",   1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk("b_to2_e72",  29, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      vecs.push_back(mk("b_p2_e73",    1, 1, 0, 0, 1, 0, 0, 0, 0, 2));
      vecs.push_back(mk("b_to3_e108", 35, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      vecs.push_back(mk("b_fail",      1, 1, 0, 0, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk("b_fail_hold",20, 1, 0, 0, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk("b_fail_rq",   1, 1, 0, 1, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk("b_restart",   1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("b_rs_end",    3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("b_wait",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n      = vecs[i].rst_n;
         pll_locked = vecs[i].locked;
         relock_req = vecs[i].relock;
         step(vecs[i].n);
         check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      end
      relock_req = 1'b0;

      // One-cycle lock glitch while qualifying restarts the stable count
      pll_locked = 1'b0;
      do_reset();
      step(5);
      pll_locked = 1'b1;
      step(7);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      wait_ready(40, lat);
      check("stable_glitch_latency", 32'(lat), 32'd12);

      // Loss of lock in RUN
      do_reset();
      wait_ready(60, lat);
      check("bringup_ready", 32'(ready), 32'd1);
      pll_locked = 1'b0;
      step(2);
      check("lol_pre", 32'({lol, ready}), 32'b01);
      step(1);
      check("lol_pulse", 32'({lol, sys_rst_n, ready, pll_rst}), 32'b1110);
      step(1);
      check("lol_after", 32'({lol, sys_rst_n, ready, pll_rst}), 32'b0001);
      w = 1;
      guard = 0;
      while (pll_rst && guard < 20) begin
         step(1);
         guard++;
         if (pll_rst) w++;
      end
      check("lol_pllrst_width", 32'(w), 32'd4);
      pll_locked = 1'b1;
      wait_ready(60, lat);
      check("lol_recover", 32'(lat > 0), 32'd1);

      // Loss of lock and relock request in the same cycle
      pll_locked = 1'b0;
      step(2);
      relock_req = 1'b1;
      step(1);
      relock_req = 1'b0;
      lol_cnt  = (lol === 1'b1) ? 1 : 0;
      rise_cnt = 0;
      prev     = pll_rst;
      for (int k = 0; k < 30; k++) begin
         step(1);
         if (lol === 1'b1) lol_cnt++;
         if (pll_rst && !prev) rise_cnt++;
         prev = pll_rst;
      end
      check("both_lol_count", 32'(lol_cnt), 32'd1);
      check("both_rst_entries", 32'(rise_cnt), 32'd1);

      // Asynchronous reset in WAIT_LOCK with one retry consumed
      @(negedge refclk);
      pll_locked = 1'b0;
      do_reset();
      step(45);
      check("async_pre_retry", 32'(retry_cnt), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_wait", 32'(outs()), 32'(9'b1_0000_0000));

      // Asynchronous reset in RUN: no lol, full pulse after release
      @(negedge refclk);
      pll_locked = 1'b1;
      do_reset();
      wait_ready(60, lat);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_run", 32'(outs()), 32'(9'b1_0000_0000));
      @(negedge refclk);
      rst_n = 1'b1;
      w = 0;
      for (int k = 0; k < 8; k++) begin
         step(1);
         if (pll_rst) w++;
      end
      check("rerelease_pulse", 32'(w), 32'd4);

      check("rst_exclusive", 32'(excl_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
